// File: rtl/fft_r22_bf_stage.sv
// Radix-2^2 single-delay-feedback butterfly stage (BF-I or BF-II) with its own
// valid-sample counter, stall support and optional rounded 1/2 output scaling.
module fft_r22_bf_stage #(
    parameter int WIDTH = 24,
    parameter int DELAY = 512,
    parameter int MODE  = 0,
    parameter int SCALE = 0,
    localparam int OW   = (SCALE != 0) ? WIDTH : WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    srst_n,
    input  logic                    valid_i,
    input  logic                    sof_i,
    input  logic signed [WIDTH-1:0] x_re_i,
    input  logic signed [WIDTH-1:0] x_im_i,
    output logic                    valid_o,
    output logic                    sof_o,
    output logic signed [OW-1:0]    z_re_o,
    output logic signed [OW-1:0]    z_im_o
);
    localparam int L  = $clog2(DELAY);
    localparam int IW = WIDTH + 1;
    localparam int CW = L + 2;
    localparam logic [CW-1:0] D_CNT = CW'(DELAY);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0]        cnt;
    logic [CW-1:0]        ecnt;
    logic                 primed;
    logic                 sel;
    logic                 rot;
    logic                 at_d;
    logic                 live;
    logic signed [IW-1:0] xe_re, xe_im;
    logic signed [IW-1:0] a_re, a_im;
    logic signed [IW-1:0] sr_re_out, sr_im_out;
    logic signed [IW-1:0] m_re, m_im;
    logic signed [IW-1:0] w_re, w_im;
    logic signed [OW-1:0] zn_re, zn_im;
    logic signed [IW-1:0] sr_re [DELAY];
    logic signed [IW-1:0] sr_im [DELAY];

    // A sample flagged sof_i is position 0 of a new frame regardless of cnt
    assign ecnt = sof_i ? '0 : cnt;
    assign sel  = ecnt[L];
    assign rot  = (MODE == 1) && ecnt[L] && ecnt[L+1];
    assign at_d = (ecnt == D_CNT);
    assign live = primed && !sof_i;

    assign xe_re = {x_re_i[WIDTH-1], x_re_i};
    assign xe_im = {x_im_i[WIDTH-1], x_im_i};

    // Trivial -j rotation: (re, im) -> (im, -re)
    assign a_re = rot ? xe_im : xe_re;
    assign a_im = rot ? -xe_re : xe_im;

    assign sr_re_out = sr_re[DELAY-1];
    assign sr_im_out = sr_im[DELAY-1];

    assign m_re = sel ? a_re + sr_re_out : sr_re_out;
    assign m_im = sel ? a_im + sr_im_out : sr_im_out;
    assign w_re = sel ? sr_re_out - a_re : a_re;
    assign w_im = sel ? sr_im_out - a_im : a_im;

    generate
        if (SCALE != 0) begin : g_half
            // One guard bit so the +1 rounding term cannot wrap
            logic signed [IW:0] r_re, r_im;
            assign r_re  = {m_re[IW-1], m_re} + (IW+1)'(1);
            assign r_im  = {m_im[IW-1], m_im} + (IW+1)'(1);
            assign zn_re = OW'(r_re >>> 1);
            assign zn_im = OW'(r_im >>> 1);
        end else begin : g_full
            assign zn_re = m_re;
            assign zn_im = m_im;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (valid_i) begin
            sr_re[0] <= w_re;
            sr_im[0] <= w_im;
            for (int i = 1; i < DELAY; i++) begin
                sr_re[i] <= sr_re[i-1];
                sr_im[i] <= sr_im[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            cnt     <= '0;
            primed  <= 1'b0;
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
            z_re_o  <= '0;
            z_im_o  <= '0;
        end else begin
            valid_o <= valid_i && (live || at_d);
            sof_o   <= valid_i && at_d && !live;
            if (valid_i) begin
                cnt    <= ecnt + ONE;
                primed <= live || at_d;
                z_re_o <= zn_re;
                z_im_o <= zn_im;
            end
        end
    end
endmodule
